// File: rtl/dal_arbiter_if.sv
// Requester-side and pin-side signals of the BDAL transmit arbiter.
// slave = the arbiter; master = device models / pin logic driving requests.
interface dal_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]      req;
   logic [22*NREQ-1:0]   req_dal;
   logic [NREQ-1:0]      req_wtbt;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      drive;
   logic                 DALtx;
   logic                 DALst;
   logic                 DALbe_L;
   logic [21:0]          TDAL;
   logic                 TWTBT;
   logic                 timeout;

   modport slave (
      input  req, req_dal, req_wtbt,
      output gnt, drive, DALtx, DALst, DALbe_L, TDAL, TWTBT, timeout
   );

   modport master (
      output req, req_dal, req_wtbt,
      input  gnt, drive, DALtx, DALst, DALbe_L, TDAL, TWTBT, timeout
   );
endinterface

// File: rtl/dal_arbiter.sv
// Rotating-priority arbiter for the shared BDAL/Am2908 transmit path: sequences DALtx, DALst,
// DALbe_L for the granted requester and muxes its TDAL/TWTBT; watchdog forces a stuck holder off.
module dal_arbiter #(
   parameter int NREQ    = 3,
   parameter int SETTLE  = 2,
   parameter int TURN    = 1,
   parameter int TIMEOUT = 64
) (
   input  logic         clk20,
   input  logic         reset_L,
   dal_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_LATCH,
      S_DRIVE,
      S_RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] blocked_q, blocked_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] drive_q, drive_d;
   logic            tx_q, tx_d;
   logic            st_q, st_d;
   logic            be_l_q, be_l_d;
   logic            timeout_q, timeout_d;

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] win_onehot;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   next_ptr;
   logic [IW-1:0]   idx_w;
   logic            any_elig;
   logic            req_held;
   logic            rel;
   int              idx;

   assign eligible = bus.req & ~blocked_q;
   assign req_held = |(bus.req & gnt_q);

   // Scan from the highest offset down so the candidate closest to rr_ptr wins last.
   always_comb begin
      any_elig = 1'b0;
      win_idx  = '0;
      idx      = 0;
      idx_w    = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx   = (int'(rr_ptr_q) + off) % NREQ;
         idx_w = IW'(idx);
         if (eligible[idx_w]) begin
            any_elig = 1'b1;
            win_idx  = idx_w;
         end
      end
   end

   assign next_ptr = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_onehot[i] = (win_idx == IW'(i));
      end
   end

   always_comb begin
      bus.TDAL  = '0;
      bus.TWTBT = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            bus.TDAL  = bus.TDAL | bus.req_dal[22*i +: 22];
            bus.TWTBT = bus.TWTBT | bus.req_wtbt[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wdog_d    = wdog_q;
      rr_ptr_d  = rr_ptr_q;
      blocked_d = blocked_q & bus.req;
      gnt_d     = gnt_q;
      drive_d   = drive_q;
      tx_d      = tx_q;
      st_d      = 1'b0;
      be_l_d    = be_l_q;
      timeout_d = 1'b0;
      rel       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               gnt_d    = win_onehot;
               tx_d     = 1'b1;
               rr_ptr_d = next_ptr;
               cnt_d    = '0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!req_held) begin
               rel = 1'b1;
            end else if (cnt_q == 4'(SETTLE - 1)) begin
               st_d    = 1'b1;
               state_d = S_LATCH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_LATCH: begin
            if (!req_held) begin
               rel = 1'b1;
            end else begin
               be_l_d  = 1'b0;
               drive_d = gnt_q;
               wdog_d  = '0;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (!req_held) begin
               be_l_d  = 1'b1;
               drive_d = '0;
               rel     = 1'b1;
            end else if ((TIMEOUT != 0) && (wdog_q == WW'(TIMEOUT - 1))) begin
               timeout_d = 1'b1;
               blocked_d = blocked_d | gnt_q;
               be_l_d    = 1'b1;
               drive_d   = '0;
               rel       = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_RELEASE: begin
            if ((TURN == 0) || (cnt_q == 4'(TURN - 1))) begin
               tx_d    = 1'b0;
               gnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // With no turnaround the driver side drops DALtx together with DALbe_L.
      if (rel) begin
         cnt_d = '0;
         if (TURN == 0) begin
            tx_d    = 1'b0;
            gnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            state_d = S_RELEASE;
         end
      end
   end

   always_ff @(posedge clk20 or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wdog_q    <= '0;
         rr_ptr_q  <= '0;
         blocked_q <= '0;
         gnt_q     <= '0;
         drive_q   <= '0;
         tx_q      <= 1'b0;
         st_q      <= 1'b0;
         be_l_q    <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wdog_q    <= wdog_d;
         rr_ptr_q  <= rr_ptr_d;
         blocked_q <= blocked_d;
         gnt_q     <= gnt_d;
         drive_q   <= drive_d;
         tx_q      <= tx_d;
         st_q      <= st_d;
         be_l_q    <= be_l_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.drive   = drive_q;
   assign bus.DALtx   = tx_q;
   assign bus.DALst   = st_q;
   assign bus.DALbe_L = be_l_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_dal_arbiter.sv
// Directed bench for dal_arbiter (NREQ=3, SETTLE=2, TURN=1, TIMEOUT=8) with a negedge invariant monitor.
module tb_dal_arbiter;
   logic clk20   = 1'b0;
   logic reset_L = 1'b1;
   logic mon_en  = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   dal_arbiter_if #(.NREQ(3)) bus ();

   dal_arbiter #(
      .NREQ   (3),
      .SETTLE (2),
      .TURN   (1),
      .TIMEOUT(8)
   ) dut (
      .clk20  (clk20),
      .reset_L(reset_L),
      .bus    (bus)
   );

   always #5 clk20 = ~clk20;

   always @(negedge clk20) begin
      if (mon_en && reset_L) begin
         total++;
         if (!bus.DALbe_L && !bus.DALtx) begin
            bad++; $display("FAIL inv_be_tx: DALbe_L=%b DALtx=%b, DALtx required 1", bus.DALbe_L, bus.DALtx);
         end
         total++;
         if (bus.DALst && !bus.DALbe_L) begin
            bad++; $display("FAIL inv_st_be: DALst=%b DALbe_L=%b, not both active", bus.DALst, bus.DALbe_L);
         end
         total++;
         if (!$onehot0(bus.gnt) || !$onehot0(bus.drive)) begin
            bad++; $display("FAIL inv_onehot: gnt=%b drive=%b, at most one-hot required", bus.gnt, bus.drive);
         end
      end
   end

   task automatic tick();
      @(posedge clk20);
      #1;
   endtask

   task automatic apply_reset();
      reset_L      = 1'b0;
      bus.req      = '0;
      bus.req_dal  = '0;
      bus.req_wtbt = '0;
      @(posedge clk20);
      @(posedge clk20);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      bus.req      = 3'b111;
      bus.req_dal  = {22'o1, 22'o2, 22'o3};
      bus.req_wtbt = 3'b111;
      #1 reset_L = 1'b0;
      #2;
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt: got %b want 000", bus.gnt); end
      total++; if (bus.drive !== 3'b000) begin bad++; $display("FAIL rst_drive: got %b want 000", bus.drive); end
      total++; if (bus.DALtx !== 1'b0) begin bad++; $display("FAIL rst_tx: got %b want 0", bus.DALtx); end
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL rst_st: got %b want 0", bus.DALst); end
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL rst_be: got %b want 1", bus.DALbe_L); end
      total++; if (bus.TDAL !== 22'o0) begin bad++; $display("FAIL rst_tdal: got %o want 0", bus.TDAL); end
      total++; if (bus.TWTBT !== 1'b0) begin bad++; $display("FAIL rst_twtbt: got %b want 0", bus.TWTBT); end
      total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", bus.timeout); end
      tick();
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rst_hold_gnt: got %b want 000", bus.gnt); end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      bus.req_dal  = {22'o0, 22'o0, 22'o1234567};
      bus.req_wtbt = 3'b001;
      bus.req      = 3'b001;
      tick(); // edge 1
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL t1_gnt_e1: got %b want 001", bus.gnt); end
      total++; if (bus.DALtx !== 1'b1) begin bad++; $display("FAIL t1_tx_e1: got %b want 1", bus.DALtx); end
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL t1_st_e1: got %b want 0", bus.DALst); end
      total++; if (bus.TDAL !== 22'o1234567) begin bad++; $display("FAIL t1_tdal: got %o want 1234567", bus.TDAL); end
      total++; if (bus.TWTBT !== 1'b1) begin bad++; $display("FAIL t1_twtbt: got %b want 1", bus.TWTBT); end
      tick(); // edge 2
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL t1_st_e2: got %b want 0", bus.DALst); end
      tick(); // edge 3
      total++; if (bus.DALst !== 1'b1) begin bad++; $display("FAIL t1_st_e3: got %b want 1", bus.DALst); end
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL t1_be_e3: got %b want 1", bus.DALbe_L); end
      tick(); // edge 4
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL t1_st_e4: got %b want 0", bus.DALst); end
      total++; if (bus.DALbe_L !== 1'b0) begin bad++; $display("FAIL t1_be_e4: got %b want 0", bus.DALbe_L); end
      total++; if (bus.drive !== 3'b001) begin bad++; $display("FAIL t1_drive_e4: got %b want 001", bus.drive); end
      bus.req_dal[21:0] = 22'o7654321;
      #1;
      total++; if (bus.TDAL !== 22'o7654321) begin bad++; $display("FAIL t1_tdal_track: got %o want 7654321", bus.TDAL); end
      bus.req = 3'b000;
      tick(); // edge 5
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL t1_be_rel: got %b want 1", bus.DALbe_L); end
      total++; if (bus.drive !== 3'b000) begin bad++; $display("FAIL t1_drive_rel: got %b want 000", bus.drive); end
      total++; if (bus.DALtx !== 1'b1) begin bad++; $display("FAIL t1_tx_turn: got %b want 1", bus.DALtx); end
      tick(); // edge 6
      total++; if (bus.DALtx !== 1'b0) begin bad++; $display("FAIL t1_tx_off: got %b want 0", bus.DALtx); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL t1_gnt_off: got %b want 000", bus.gnt); end
      total++; if (bus.TDAL !== 22'o0) begin bad++; $display("FAIL t1_tdal_off: got %o want 0", bus.TDAL); end
   endtask

   task automatic test_round_robin();
      int          exp_order[4] = '{0, 1, 2, 0};
      logic [2:0]  want;
      int          waited;
      apply_reset();
      bus.req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         want   = 3'b001 << exp_order[k];
         waited = 0;
         while (bus.drive === 3'b000 && waited < 30) begin
            tick();
            waited++;
         end
         total++;
         if (bus.drive !== want) begin
            bad++; $display("FAIL rr_order_%0d: drive=%b want %b", k, bus.drive, want);
         end
         repeat (5) tick();
         bus.req[exp_order[k]] = 1'b0;
         tick();
         bus.req[exp_order[k]] = 1'b1;
      end
      bus.req = 3'b000;
      repeat (8) tick();
   endtask

   task automatic test_abort();
      apply_reset();
      bus.req = 3'b010;
      tick(); // edge 1: granted
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL ab_gnt: got %b want 010", bus.gnt); end
      bus.req = 3'b000;
      tick(); // edge 2: release
      total++; if (bus.DALtx !== 1'b1) begin bad++; $display("FAIL ab_tx_turn: got %b want 1", bus.DALtx); end
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL ab_st_e2: got %b want 0", bus.DALst); end
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL ab_be_e2: got %b want 1", bus.DALbe_L); end
      tick(); // edge 3: idle
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL ab_st_e3: got %b want 0", bus.DALst); end
      total++; if (bus.DALtx !== 1'b0) begin bad++; $display("FAIL ab_tx_off: got %b want 0", bus.DALtx); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL ab_gnt_off: got %b want 000", bus.gnt); end
      tick();
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL ab_be_e4: got %b want 1", bus.DALbe_L); end
   endtask

   task automatic test_watchdog();
      apply_reset();
      bus.req = 3'b100;
      repeat (4) tick(); // edge 4: drive starts
      total++; if (bus.drive !== 3'b100) begin bad++; $display("FAIL wd_drive: got %b want 100", bus.drive); end
      repeat (7) tick(); // edge 11
      total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", bus.timeout); end
      total++; if (bus.drive !== 3'b100) begin bad++; $display("FAIL wd_drive_e11: got %b want 100", bus.drive); end
      tick(); // edge 12
      total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL wd_pulse: got %b want 1", bus.timeout); end
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL wd_be: got %b want 1", bus.DALbe_L); end
      total++; if (bus.drive !== 3'b000) begin bad++; $display("FAIL wd_drive_off: got %b want 000", bus.drive); end
      tick(); // edge 13
      total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL wd_pulse_end: got %b want 0", bus.timeout); end
      total++; if (bus.DALtx !== 1'b0) begin bad++; $display("FAIL wd_tx_off: got %b want 0", bus.DALtx); end
      repeat (2) tick(); // edge 15
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL wd_blocked: got %b want 000", bus.gnt); end
      bus.req = 3'b000;
      tick();
      bus.req = 3'b100;
      tick();
      total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL wd_regrant: got %b want 100", bus.gnt); end
      bus.req = 3'b000;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid_drive();
      apply_reset();
      bus.req = 3'b001;
      repeat (4) tick();
      total++; if (bus.drive !== 3'b001) begin bad++; $display("FAIL rm_drive: got %b want 001", bus.drive); end
      #2 reset_L = 1'b0;
      #1;
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL rm_be: got %b want 1", bus.DALbe_L); end
      total++; if (bus.DALtx !== 1'b0) begin bad++; $display("FAIL rm_tx: got %b want 0", bus.DALtx); end
      total++; if (bus.DALst !== 1'b0) begin bad++; $display("FAIL rm_st: got %b want 0", bus.DALst); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rm_gnt: got %b want 000", bus.gnt); end
      bus.req = 3'b011;
      tick();
      reset_L = 1'b1;
      tick();
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL rm_ptr0: got %b want 001", bus.gnt); end
      bus.req = 3'b000;
      repeat (4) tick();
   endtask

   task automatic test_release_contention();
      apply_reset();
      bus.req = 3'b010;
      repeat (5) tick(); // edge 5, in drive
      bus.req = 3'b000;
      tick(); // edge 6: release
      total++; if (bus.DALbe_L !== 1'b1) begin bad++; $display("FAIL rc_be: got %b want 1", bus.DALbe_L); end
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL rc_gnt_held: got %b want 010", bus.gnt); end
      bus.req = 3'b001;
      tick(); // edge 7: idle
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rc_idle: got %b want 000", bus.gnt); end
      tick(); // edge 8
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL rc_gnt0: got %b want 001", bus.gnt); end
      total++; if (bus.DALtx !== 1'b1) begin bad++; $display("FAIL rc_tx: got %b want 1", bus.DALtx); end
      bus.req = 3'b000;
      repeat (4) tick();
   endtask

   initial begin
      bus.req      = '0;
      bus.req_dal  = '0;
      bus.req_wtbt = '0;
      test_reset();
      mon_en = 1'b1;
      test_single();
      test_round_robin();
      test_abort();
      test_watchdog();
      test_reset_mid_drive();
      test_release_contention();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
